// File: rtl/kyber_hash_pkg.sv
// Shared types and constants for the Kyber hash-core scheduler.
// Mode codes match the hash core's ififo_mode tag encoding.
package kyber_hash_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] MODE_SHA512   = 2'd0;
    localparam logic [1:0] MODE_SHA256   = 2'd1;
    localparam logic [1:0] MODE_SHAKE256 = 2'd2;
    localparam logic [1:0] MODE_SHAKE128 = 2'd3;

    localparam logic [5:0] RATE0 = 6'd18;
    localparam logic [5:0] RATE1 = 6'd34;
    localparam logic [5:0] RATE2 = 6'd34;
    localparam logic [5:0] RATE3 = 6'd42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ABSORB,
        S_WAIT_P,
        S_BLOCK,
        S_EXTEND,
        S_WAIT_X,
        S_FIN
    } state_e;

    function automatic logic [5:0] rate_of(input logic [1:0] m);
        logic [5:0] r;
        case (m)
            MODE_SHA512:   r = RATE0;
            MODE_SHA256:   r = RATE1;
            MODE_SHAKE256: r = RATE2;
            default:       r = RATE3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kyber_hash_sched_arb.sv
// Three-way round-robin pick: first request at or after the pointer.
// Falls back to the lowest request when nothing sits at/above the pointer.
module rr_arbiter3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o
);

    logic [2:0] hi;

    always_comb begin
        hi = req_i & (3'b111 << ptr_i);
        if (|hi) begin
            gnt_o = hi & (~hi + 3'd1);
        end else begin
            gnt_o = req_i & (~req_i + 3'd1);
        end
    end

endmodule

// File: rtl/kyber_hash_sched.sv
// Round-robin job sequencer sharing one Keccak hash core between
// matrix-A, CBD noise and G/H requesters.
module kyber_hash_sched
    import kyber_hash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [5:0]  req_mode,
    input  logic [17:0] req_len,
    input  logic [11:0] req_ext,
    input  logic [95:0] src_din,
    input  logic [2:0]  src_vld,
    output logic [2:0]  src_rd,
    input  logic [2:0]  drain_ack,
    output logic [2:0]  grant,
    output logic [2:0]  blk_rdy,
    output logic [2:0]  done,
    output logic        keccak_init,
    output logic        ififo_wen,
    output logic [31:0] ififo_din,
    output logic        ififo_absorb,
    output logic [1:0]  ififo_mode,
    output logic        ififo_last,
    output logic        extend,
    input  logic        ififo_full,
    input  logic        keccak_ready,
    input  logic [5:0]  squeeze_ctr
);

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] gidx_q, gidx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] mode_q, mode_d;
    logic [5:0] len_q, len_d;
    logic [3:0] ext_q, ext_d;
    logic [5:0] wc_q, wc_d;
    logic [2:0] blk_q, blk_d;
    logic [2:0] done_q, done_d;
    logic       init_q, init_d;
    logic       xt_q, xt_d;
    logic       absorb_q, absorb_d;
    logic       last_q, last_d;
    logic       rdy_q;

    logic [2:0]  pick;
    logic [1:0]  pick_idx;
    logic [1:0]  mode_sel;
    logic [5:0]  len_sel;
    logic [3:0]  ext_sel;
    logic [31:0] din_sel;
    logic        vld_g;
    logic        wen;
    logic        rise;

    rr_arbiter3 u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        unique case (1'b1)
            pick[1]: pick_idx = 2'd1;
            pick[2]: pick_idx = 2'd2;
            default: pick_idx = 2'd0;
        endcase
    end

    always_comb begin
        mode_sel = '0;
        len_sel  = '0;
        ext_sel  = '0;
        din_sel  = '0;
        vld_g    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                mode_sel = req_mode[2*i +: 2];
                len_sel  = req_len[6*i +: 6];
                ext_sel  = req_ext[4*i +: 4];
            end
            if (grant_q[i]) begin
                din_sel = din_sel | src_din[32*i +: 32];
                vld_g   = vld_g | src_vld[i];
            end
        end
    end

    assign wen       = (state_q == S_ABSORB) & vld_g & ~ififo_full;
    assign rise      = keccak_ready & ~rdy_q;
    assign ififo_wen = wen;
    assign src_rd    = wen ? grant_q : 3'b000;
    assign ififo_din = (state_q == S_ABSORB) ? din_sel : 32'd0;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        len_d    = len_q;
        ext_d    = ext_q;
        wc_d     = wc_q;
        blk_d    = '0;
        done_d   = '0;
        init_d   = 1'b0;
        xt_d     = 1'b0;
        absorb_d = 1'b0;
        last_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    mode_d  = mode_sel;
                    len_d   = (len_sel == 6'd0) ? 6'd1 : len_sel;
                    ext_d   = ext_sel;
                    init_d  = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                wc_d     = '0;
                absorb_d = 1'b1;
                last_d   = (len_q == 6'd1);
                state_d  = S_ABSORB;
            end
            S_ABSORB: begin
                absorb_d = 1'b1;
                last_d   = last_q;
                if (wen) begin
                    wc_d   = wc_q + 6'd1;
                    last_d = (wc_q + 6'd2 == len_q);
                    if (last_q) begin
                        absorb_d = 1'b0;
                        last_d   = 1'b0;
                        state_d  = S_WAIT_P;
                    end
                end
            end
            S_WAIT_P, S_WAIT_X: begin
                if (rise) begin
                    blk_d   = grant_q;
                    state_d = S_BLOCK;
                end
            end
            S_BLOCK: begin
                blk_d = grant_q;
                if (|(drain_ack & grant_q)) begin
                    blk_d = '0;
                    if (ext_q == 4'd0) begin
                        done_d  = grant_q;
                        state_d = S_FIN;
                    end else begin
                        ext_d   = ext_q - 4'd1;
                        xt_d    = 1'b1;
                        state_d = S_EXTEND;
                    end
                end
            end
            S_EXTEND: begin
                xt_d = 1'b1;
                if (squeeze_ctr == rate_of(mode_q) - 6'd1) begin
                    xt_d    = 1'b0;
                    state_d = S_WAIT_X;
                end
            end
            S_FIN: begin
                grant_d = '0;
                ptr_d   = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            mode_q   <= '0;
            len_q    <= '0;
            ext_q    <= '0;
            wc_q     <= '0;
            blk_q    <= '0;
            done_q   <= '0;
            init_q   <= 1'b0;
            xt_q     <= 1'b0;
            absorb_q <= 1'b0;
            last_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            ext_q    <= ext_d;
            wc_q     <= wc_d;
            blk_q    <= blk_d;
            done_q   <= done_d;
            init_q   <= init_d;
            xt_q     <= xt_d;
            absorb_q <= absorb_d;
            last_q   <= last_d;
            rdy_q    <= keccak_ready;
        end
    end

    assign grant        = grant_q;
    assign blk_rdy      = blk_q;
    assign done         = done_q;
    assign keccak_init  = init_q;
    assign extend       = xt_q;
    assign ififo_absorb = absorb_q;
    assign ififo_mode   = mode_q;
    assign ififo_last   = last_q;

endmodule

// File: tb/tb_kyber_hash_sched.sv
// Randomized bench for kyber_hash_sched with a job-level reference model
// of the requesters, the hash core and the consumer.
module tb_kyber_hash_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [5:0]  req_mode = '0;
    logic [17:0] req_len = '0;
    logic [11:0] req_ext = '0;
    logic [95:0] src_din = '0;
    logic [2:0]  src_vld = '0;
    logic [2:0]  src_rd;
    logic [2:0]  drain_ack = '0;
    logic [2:0]  grant, blk_rdy, done;
    logic        keccak_init, ififo_wen;
    logic [31:0] ififo_din;
    logic        ififo_absorb;
    logic [1:0]  ififo_mode;
    logic        ififo_last, extend;
    logic        ififo_full = 1'b0;
    logic        keccak_ready = 1'b0;
    logic [5:0]  squeeze_ctr = '0;

    always #5 clk = ~clk;

    kyber_hash_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_mode     (req_mode),
        .req_len      (req_len),
        .req_ext      (req_ext),
        .src_din      (src_din),
        .src_vld      (src_vld),
        .src_rd       (src_rd),
        .drain_ack    (drain_ack),
        .grant        (grant),
        .blk_rdy      (blk_rdy),
        .done         (done),
        .keccak_init  (keccak_init),
        .ififo_wen    (ififo_wen),
        .ififo_din    (ififo_din),
        .ififo_absorb (ififo_absorb),
        .ififo_mode   (ififo_mode),
        .ififo_last   (ififo_last),
        .extend       (extend),
        .ififo_full   (ififo_full),
        .keccak_ready (keccak_ready),
        .squeeze_ctr  (squeeze_ctr)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // requester side
    int          rmode[3], rlen[3], rext[3], spos[3];
    logic [31:0] words[3][64];
    bit          auto_on = 0;

    // job model: mst 0 idle, 1 busy, 2 finishing
    int   mst = 0, ptr = 0, jobs_done = 0;
    int   jg = 0, jm = 0, jl = 1, jx = 0;
    int   nwr = 0, nblk = 0, xrun = 0, age = 0;
    int   ack_cnt = -1, rd_cnt = 0, rd_hold = 0, fburst = 0;
    bit   acked = 0, prev_blk = 0, prev_xt = 0;
    logic [2:0] req_drv = '0;

    function automatic int rate(int m);
        case (m)
            0: return 18;
            1: return 34;
            2: return 34;
            default: return 42;
        endcase
    endfunction

    function automatic logic [2:0] rr_pick(logic [2:0] r, int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return 3'(1 << ((p + k) % 3));
        return 3'b000;
    endfunction

    task automatic raise(int i, int m, int l, int x);
        rmode[i] = m;
        rlen[i]  = l;
        rext[i]  = x;
        spos[i]  = 0;
        for (int k = 0; k < 64; k++) words[i][k] = $urandom;
        req_mode[2*i +: 2] = 2'(m);
        req_len[6*i +: 6]  = 6'(l);
        req_ext[4*i +: 4]  = 4'(x);
        req[i] = 1'b1;
    endtask

    task automatic cycle();
        logic [2:0] oh, exp;
        bit ew;
        req_drv = req;
        @(negedge clk);
        oh = 3'(1 << jg);
        if (mst != 1) begin
            if (mst == 0 && req_drv != 3'b000) begin
                exp = rr_pick(req_drv, ptr);
                chk("grant_pick", grant, exp);
                chk("init_pulse", keccak_init, 1);
                jg = exp[1] ? 1 : (exp[2] ? 2 : 0);
                jm = rmode[jg];
                jl = (rlen[jg] == 0) ? 1 : rlen[jg];
                jx = rext[jg];
                nwr = 0; nblk = 0; xrun = 0; age = 0;
                acked = 0; ack_cnt = -1; prev_blk = 0; prev_xt = 0;
                mst = 1;
            end else begin
                chk("grant_idle", grant, 0);
                chk("init_idle", keccak_init, 0);
                chk("done_idle", done, 0);
                chk("blk_idle", blk_rdy, 0);
                mst = 0;
            end
            oh = 3'(1 << jg);
        end else begin
            age++;
            chk("grant_hold", grant, oh);
            chk("init_busy", keccak_init, 0);
            chk("absorb_tag", ififo_absorb, nwr < jl);
            chk("blk_other", blk_rdy & ~oh, 0);
            if (acked) begin
                chk("blk_after_ack", blk_rdy, 0);
                if (nblk == jx + 1) chk("done_after_ack", done, oh);
                else chk("ext_after_ack", extend, 1);
                acked = 0;
            end
            if (blk_rdy[jg] && !prev_blk) begin
                nblk++;
                ack_cnt = $urandom_range(0, 3);
            end
            if (extend) xrun++;
            else if (prev_xt) begin
                chk("extend_len", xrun, rate(jm));
                xrun = 0;
                rd_cnt = $urandom_range(1, 5);
            end
            if (done != 3'b000) begin
                chk("done_oh", done, oh);
                chk("blocks", nblk, jx + 1);
                chk("words", nwr, jl);
                req[jg] = 1'b0;
                ptr = (jg + 1) % 3;
                jobs_done++;
                mst = 2;
            end
            prev_blk = blk_rdy[jg];
            prev_xt  = extend;
        end

        drain_ack = '0;
        if (mst == 1 && blk_rdy[jg]) begin
            if (ack_cnt == 0) begin
                drain_ack = oh;
                acked = 1;
                ack_cnt = -1;
            end else if (ack_cnt > 0) ack_cnt--;
            drain_ack = drain_ack | (3'($urandom) & ~oh);
        end else if (blk_rdy == 3'b000 && $urandom_range(0, 7) == 0) begin
            drain_ack = 3'($urandom);
        end

        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                keccak_ready = 1'b1;
                rd_hold = $urandom_range(1, 3);
            end
        end else if (rd_hold > 0) begin
            rd_hold--;
            if (rd_hold == 0) keccak_ready = 1'b0;
        end

        squeeze_ctr = extend ? 6'(xrun - 1) : 6'($urandom);

        if (fburst > 0) begin
            ififo_full = 1'b1;
            fburst--;
        end else begin
            ififo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) fburst = 5;
        end

        if (mst == 1 && $urandom_range(0, 199) == 0) req[jg] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (auto_on && !req[i] && !(mst != 0 && i == jg)
                && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: raise(i, $urandom_range(0, 3), 0, $urandom_range(0, 2));
                    1: raise(i, $urandom_range(0, 3), 63, $urandom_range(0, 1));
                    default: raise(i, $urandom_range(0, 3), $urandom_range(1, 40),
                                   ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 3));
                endcase
            end
            src_vld[i] = ($urandom_range(0, 9) < 7);
            src_din[32*i +: 32] = (spos[i] < 64) ? words[i][spos[i]] : 32'hdead_beef;
        end

        #1;
        ew = (mst == 1) && (age >= 1) && (nwr < jl) && src_vld[jg] && !ififo_full;
        chk("wen", ififo_wen, ew);
        chk("src_rd", src_rd, ew ? oh : 3'b000);
        if (ew && ififo_wen) begin
            chk("din", ififo_din, words[jg][nwr]);
            chk("mode_tag", ififo_mode, jm);
            chk("last_tag", ififo_last, nwr == jl - 1);
            nwr++;
            spos[jg]++;
            if (nwr == jl) rd_cnt = $urandom_range(1, 5);
        end
    endtask

    task automatic run_jobs(int n);
        int tgt = jobs_done + n;
        int c = 0;
        while (jobs_done < tgt && c < 20000) begin
            cycle();
            c++;
        end
        chk("job_timeout", jobs_done >= tgt, 1);
    endtask

    task automatic run_idle();
        int c = 0;
        while (!(mst == 0 && req == 3'b000) && c < 20000) begin
            cycle();
            c++;
        end
        chk("idle_timeout", (mst == 0 && req == 3'b000), 1);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_init", keccak_init, 0);
        chk("rst_wen", ififo_wen, 0);
        #3 rst = 1'b1;

        raise(0, 0, 8, 0);
        raise(1, 1, 5, 1);
        raise(2, 2, 3, 0);
        run_jobs(3);
        raise(0, 0, 8, 0);
        run_jobs(1);
        raise(2, 3, 63, 3);
        run_jobs(1);
        raise(1, 2, 0, 2);
        run_jobs(1);

        auto_on = 1;
        run_jobs(40);
        auto_on = 0;
        run_idle();

        raise(1, 0, 3, 0);
        run_jobs(1);
        raise(0, 3, 20, 0);
        for (int c = 0; c < 500 && !(mst == 1 && nwr >= 3); c++) cycle();
        chk("mid_absorb", (mst == 1 && nwr >= 3), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_init", keccak_init, 0);
        chk("arst_wen", ififo_wen, 0);
        chk("arst_rd", src_rd, 0);
        chk("arst_din", ififo_din, 0);
        chk("arst_absorb", ififo_absorb, 0);
        chk("arst_last", ififo_last, 0);
        chk("arst_mode", ififo_mode, 0);
        chk("arst_ext", extend, 0);
        chk("arst_blk", blk_rdy, 0);
        req = '0;
        keccak_ready = 1'b0;
        drain_ack = '0;
        rd_cnt = 0; rd_hold = 0; acked = 0;
        mst = 0; ptr = 0;
        repeat (2) @(negedge clk);
        chk("arst_hold", grant, 0);
        #3 rst = 1'b1;
        raise(1, 1, 4, 0);
        raise(2, 2, 0, 1);
        run_jobs(2);
        run_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
